// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU-client types, opcode group encodings and default widths.
package alu_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_FUN_W   = 4;
    localparam int DEF_ALU_LAT = 1;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_CMP   = 2'b10;
    localparam logic [1:0] GRP_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    function automatic logic [1:0] fun_grp(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/alu_rsp_mux.sv
// alu_rsp_mux: selects the ALU result bus, carry and expected group flag for an opcode group.
module alu_rsp_mux
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]          grp,
    input  logic [2*DATA_W-1:0] arith_out,
    input  logic                carry_out,
    input  logic [DATA_W-1:0]   logic_out,
    input  logic [2:0]          cmp_out,
    input  logic [DATA_W-1:0]   shift_out,
    input  logic                arith_flag,
    input  logic                logic_flag,
    input  logic                cmp_flag,
    input  logic                shift_flag,
    output logic [2*DATA_W-1:0] data,
    output logic                carry,
    output logic                flag
);
    localparam int RW = 2 * DATA_W;

    always_comb begin
        data  = (grp == GRP_ARITH) ? arith_out
              : (grp == GRP_LOGIC) ? RW'(logic_out)
              : (grp == GRP_CMP)   ? RW'(cmp_out)
              :                      RW'(shift_out);
        carry = (grp == GRP_ARITH) & carry_out;
        flag  = (grp == GRP_ARITH) ? arith_flag
              : (grp == GRP_LOGIC) ? logic_flag
              : (grp == GRP_CMP)   ? cmp_flag
              :                      shift_flag;
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-requester front end for the shared registered ALU.
// ALU_ARB_RR_EN selects round-robin grant; without it requester 0 has fixed priority.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FUN_W   = DEF_FUN_W,
    parameter int ALU_LAT = DEF_ALU_LAT
) (
    input  logic                       CLK_TOP,
    input  logic                       RST_TOP,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][DATA_W-1:0]     req_a,
    input  logic [1:0][DATA_W-1:0]     req_b,
    input  logic [1:0][FUN_W-1:0]      req_fun,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [2*DATA_W-1:0]        rsp_data,
    output logic                       rsp_carry,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [FUN_W-1:0]           alu_fun,
    input  logic [2*DATA_W-1:0]        arith_out,
    input  logic                       carry_out,
    input  logic [DATA_W-1:0]          logic_out,
    input  logic [2:0]                 cmp_out,
    input  logic [DATA_W-1:0]          shift_out,
    input  logic                       arith_flag,
    input  logic                       logic_flag,
    input  logic                       cmp_flag,
    input  logic                       shift_flag
);
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    arb_state_t           state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           grp_q;
    logic                 g;
    logic                 acc;
    logic [2*DATA_W-1:0]  cap_data;
    logic                 cap_carry;
    logic                 cap_flag;

`ifdef ALU_ARB_RR_EN
    logic ptr;

    assign g = (&req_valid) ? ptr : req_valid[1];

    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP)
            ptr <= 1'b0;
        else if (acc)
            ptr <= ~g;
    end
`else
    assign g = ~req_valid[0];
`endif

    // Ready is gated by reset so nothing looks accepted while the block is held.
    always_comb begin
        acc       = (state == IDLE) && (req_valid != 2'b00) && !RST_TOP;
        req_ready = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
        state_nxt = (state == IDLE) ? (acc ? EXEC : IDLE)
                  : (state == EXEC) ? ((cnt == '0) ? RESP : EXEC)
                  : (rsp_ready ? IDLE : RESP);
        rsp_valid = (state == RESP);
    end

    alu_rsp_mux #(.DATA_W(DATA_W)) u_mux (
        .grp        (grp_q),
        .arith_out  (arith_out),
        .carry_out  (carry_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .data       (cap_data),
        .carry      (cap_carry),
        .flag       (cap_flag)
    );

    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP) begin
            state     <= IDLE;
            cnt       <= '0;
            grp_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                alu_a   <= req_a[g];
                alu_b   <= req_b[g];
                alu_fun <= req_fun[g];
                grp_q   <= fun_grp(req_fun[g][3:0]);
                rsp_id  <= g;
                cnt     <= CNT_W'(ALU_LAT);
            end
            // The ALU result is valid once the latency count has drained.
            if (state == EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    rsp_data  <= cap_data;
                    rsp_carry <= cap_carry;
                    rsp_err   <= ~cap_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: scoreboard bench with a registered ALU model behind the arbiter.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int DW  = 16;
    localparam int FW  = 4;
    localparam int LAT = 1;

    logic                 CLK_TOP = 1'b0;
    logic                 RST_TOP = 1'b1;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][DW-1:0]   req_a, req_b;
    logic [1:0][FW-1:0]   req_fun;
    logic                 rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [2*DW-1:0]      rsp_data;
    logic [DW-1:0]        alu_a, alu_b;
    logic [FW-1:0]        alu_fun;
    logic [2*DW-1:0]      arith_out;
    logic                 carry_out;
    logic [DW-1:0]        logic_out, shift_out;
    logic [2:0]           cmp_out;
    logic                 arith_flag, logic_flag, cmp_flag, shift_flag;

    logic                 kill_flag = 1'b0;
    logic                 force_carry = 1'b0;
    int                   n_cmp = 0;
    int                   n_bad = 0;
`ifdef ALU_ARB_RR_EN
    logic                 mptr = 1'b0;
`endif

    typedef struct packed {
        logic            id;
        logic [2*DW-1:0] data;
        logic            carry;
        logic            err;
    } exp_t;

    exp_t sb[$];

    always #5 CLK_TOP = ~CLK_TOP;

    alu_req_arbiter #(.DATA_W(DW), .FUN_W(FW), .ALU_LAT(LAT)) dut (
        .CLK_TOP    (CLK_TOP),
        .RST_TOP    (RST_TOP),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_fun    (req_fun),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fun    (alu_fun),
        .arith_out  (arith_out),
        .carry_out  (carry_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag)
    );

    // Registered ALU stand-in: samples alu_* on an edge, results valid one edge later.
    logic [16:0]   sum_c;
    logic [2*DW-1:0] ar_q;
    logic          c_q;
    logic [DW-1:0] lo_q, sh_q;
    logic [2:0]    cm_q;
    logic [3:0]    fl_q;

    assign sum_c = alu_fun[0] ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});

    always @(posedge CLK_TOP) begin
        ar_q <= {16'h0, sum_c[15:0]};
        c_q  <= sum_c[16];
        lo_q <= (alu_fun[1:0] == 2'd0) ? (alu_a & alu_b) : (alu_fun[1:0] == 2'd1) ? (alu_a | alu_b) : (alu_a ^ alu_b);
        cm_q <= {alu_a < alu_b, alu_a == alu_b, alu_a > alu_b};
        sh_q <= alu_fun[0] ? (alu_a << 1) : (alu_a >> 1);
        fl_q <= 4'b0001 << alu_fun[3:2];
    end

    assign arith_out  = ar_q;
    assign carry_out  = c_q | force_carry;
    assign logic_out  = lo_q;
    assign cmp_out    = cm_q;
    assign shift_out  = sh_q;
    assign arith_flag = fl_q[0] & ~kill_flag;
    assign logic_flag = fl_q[1] & ~kill_flag;
    assign cmp_flag   = fl_q[2] & ~kill_flag;
    assign shift_flag = fl_q[3] & ~kill_flag;

    function automatic exp_t expect_rsp(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [FW-1:0] fun, input logic kill, input logic fc);
        exp_t e;
        logic [16:0] s;
        e.id    = id;
        e.err   = kill;
        e.carry = 1'b0;
        case (fun[3:2])
            2'b00: begin
                s = fun[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
                e.data  = {16'h0, s[15:0]};
                e.carry = s[16] | fc;
            end
            2'b01: e.data = {16'h0, (fun[1:0] == 2'd0) ? (a & b) : (fun[1:0] == 2'd1) ? (a | b) : (a ^ b)};
            2'b10: e.data = {29'h0, a < b, a == b, a > b};
            default: e.data = {16'h0, fun[0] ? (a << 1) : (a >> 1)};
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_TOP);
        @(negedge CLK_TOP);
    endtask

    task automatic present(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [FW-1:0] f);
        req_valid[r] = 1'b1;
        req_a[r]     = a;
        req_b[r]     = b;
        req_fun[r]   = f;
    endtask

    // Accept one op, follow it to its response, then hand the response off.
    task automatic serve_one(input int hold);
        logic g;
        exp_t e;
        int n;
        logic [DW-1:0] a, b;
        logic [FW-1:0] f;
        #1;
`ifdef ALU_ARB_RR_EN
        g = (&req_valid) ? mptr : req_valid[1];
        mptr = ~g;
`else
        g = ~req_valid[0];
`endif
        a = req_a[g];
        b = req_b[g];
        f = req_fun[g];
        chk("grant", req_ready, g ? 2'b10 : 2'b01);
        sb.push_back(expect_rsp(g, a, b, f, kill_flag, force_carry));
        tick();
        req_valid[g] = 1'b0;
        #1;
        chk("alu_in", {alu_a, alu_b, alu_fun}, {a, b, f});
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("busy_ready", req_ready, 2'b00);
            tick();
            n++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            chk("rsp_timeout", rsp_valid, 1'b1);
            return;
        end
        chk("latency", n, LAT + 1);
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_carry", rsp_carry, e.carry);
        chk("rsp_err", rsp_err, e.err);
        repeat (hold) begin
            tick();
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_data", {rsp_id, rsp_data, rsp_carry, rsp_err}, {e.id, e.data, e.carry, e.err});
            chk("hold_ready", req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_done", rsp_valid, 1'b0);
    endtask

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_fun   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge CLK_TOP);
        req_valid = 2'b11;
        #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_data}, '0);
        chk("rst_alu", {alu_a, alu_b, alu_fun}, '0);
        req_valid = '0;
        @(negedge CLK_TOP);
        RST_TOP = 1'b0;
        @(negedge CLK_TOP);

        present(0, 16'h0018, 16'h0004, 4'h0);
        present(1, 16'h0018, 16'h0001, 4'hC);
        serve_one(0);
        serve_one(0);

        present(0, 16'h0018, 16'h0004, 4'h0);
        serve_one(0);

        force_carry = 1'b1;
        present(0, 16'h0004, 16'h0018, 4'h1);
        present(1, 16'h00F0, 16'h0F3C, 4'h6);
        serve_one(5);
        serve_one(0);
        force_carry = 1'b0;

        kill_flag = 1'b1;
        present(0, 16'h0018, 16'h0004, 4'h0);
        serve_one(0);
        kill_flag = 1'b0;

        present(1, 16'h0005, 16'h0009, 4'h8);
        serve_one(0);

        // Asynchronous reset in the middle of an op discards it.
        present(0, 16'h1234, 16'h0F0F, 4'h5);
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("mid_alu", {alu_a, alu_b, alu_fun}, {16'h1234, 16'h0F0F, 4'h5});
        present(1, 16'h0001, 16'h0002, 4'h0);
        #1;
        RST_TOP = 1'b1;
        #1;
        chk("mid_rst_rsp", {rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_data}, '0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_fun}, '0);
        chk("mid_rst_ready", req_ready, 2'b00);
`ifdef ALU_ARB_RR_EN
        mptr = 1'b0;
`endif
        tick();
        req_valid = '0;
        RST_TOP = 1'b0;
        repeat (5) begin
            tick();
            chk("no_stale", rsp_valid, 1'b0);
        end

        present(0, 16'h0018, 16'h0004, 4'h0);
        serve_one(0);

        for (int i = 0; i < 3; i++) begin
            if (!req_valid[0]) present(0, 16'h00A0 + 16'(i), 16'h0003, 4'hD);
            if (!req_valid[1]) present(1, 16'h0100, 16'h00FF + 16'(i), 4'h4);
            serve_one(0);
        end
        while (req_valid != 2'b00) serve_one(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-requester front end for the shared registered ALU datapath. It arbitrates between two operation requesters and accepts one operation at a time over a valid/ready handshake. It drives the ALU operand and function inputs, waits out the ALU latency, then selects the result bus that matches the opcode group. The result goes back with the requester ID over a held valid/ready response channel.

## Interface
- DATA_W, 16, operand width (ALU A/B width)
- FUN_W, 4, ALU function code width
- ALU_LAT, 1, clock edges from ALU input sampling to valid ALU outputs (≥1)
- CLK_TOP  in  1  clock, rising edge
- RST_TOP  in  1  asynchronous, active-high reset
- req_valid[i], i=0,1  in  1  request i valid
- req_ready[i]  out  1  request i accepted this cycle
- req_a[i] / req_b[i]  in  DATA_W  operands
- req_fun[i]  in  FUN_W  ALU function code
- rsp_valid  out  1  response valid, held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  index of the requester that issued the op
- rsp_data  out  2*DATA_W  selected ALU result, zero-extended
- rsp_carry  out  1  ALU carry_out for arithmetic ops, else 0
- rsp_err  out  1  expected ALU group flag was not set at capture
- alu_a / alu_b  out  DATA_W  to ALU operand inputs (registered)
- alu_fun  out  FUN_W  to ALU function input (registered)
- arith_out  in  2*DATA_W; carry_out  in  1; logic_out  in  DATA_W; cmp_out  in  3; shift_out  in  DATA_W
- arith_flag, logic_flag, cmp_flag, shift_flag  in  1  ALU group flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant is combinational from req_valid and the round-robin pointer.
  - req_ready[g] = 1 only for the granted valid requester. The other requester's req_ready is 0.
  - On accept: load alu_a/alu_b/alu_fun and the latched fun, set id = g, load cnt = ALU_LAT, set pointer = ~g, go to EXEC.
- **EXEC**
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture the response and go to RESP.
- **Capture**, keyed on latched fun[3:2]:
  - 00: rsp_data = arith_out; rsp_carry = carry_out; expected flag = arith_flag.
  - 01: rsp_data = logic_out, zero-extended; expected flag = logic_flag.
  - 10: rsp_data = cmp_out, zero-extended; expected flag = cmp_flag.
  - 11: rsp_data = shift_out, zero-extended; expected flag = shift_flag.
  - rsp_err = ~expected flag. rsp_carry = 0 outside group 00.
- **RESP**
  - rsp_valid = 1. rsp_id, rsp_data, rsp_carry and rsp_err are stable.
  - On rsp_valid & rsp_ready, go to IDLE. There is no accept in this cycle.
- alu_a/alu_b/alu_fun hold their last values outside accept. The ALU's own reset is not driven by this block.
- Simultaneous req_valid: the pointer requester wins, and the loser's request stays pending.
- A single valid requester is always granted, whatever the pointer says.
- A requester may not change req_a/req_b/req_fun while valid and not ready.

## Timing
- Accept at edge e0; the ALU samples alu_* at e1; capture at e(1+ALU_LAT).
- rsp_valid rises after e(1+ALU_LAT), so latency is ALU_LAT+1 cycles (2 at the default).
- Minimum issue interval is ALU_LAT+3 cycles with rsp_ready held high.
- Reset, asynchronous at any time including mid-EXEC or mid-RESP:
  - state = IDLE, cnt = 0, pointer = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_carry = 0, rsp_err = 0.
  - alu_a = 0, alu_b = 0, alu_fun = 0; req_ready = 0 while reset is asserted.
  - The in-flight op is discarded with no response.

## Configuration
- ALU_ARB_RR_EN defined: round-robin grant as described; the pointer toggles on each accept.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins. The pointer register is removed.

## Structure
- Shared package (alu_pkg) holds:
  - FSM state typedef.
  - Opcode group constants (GRP_ARITH = 2'b00, GRP_LOGIC, GRP_CMP, GRP_SHIFT).
  - Default width constants.
- One sub-module: alu_rsp_mux, the combinational group-select of result, carry and expected flag, reusable by other ALU clients.

## Test plan
- Request 0: A = 0x0018, B = 0x0004, fun = 0x0, ALU_LAT = 1 → rsp_valid 2 cycles after accept; rsp_data = 0x0000001C, rsp_id = 0, rsp_err = 0.
- Both valid in the same cycle, fun 0x0 and 0xC (A = 0x0018) → requester 0 served first (0x1C), then requester 1 (rsp_data = 0x0000000C, rsp_id = 1). The next simultaneous pair is granted to requester 1 first.
- rsp_ready held low for 5 cycles → rsp_valid and data stable for all 5; no req_ready during that time; IDLE and a new accept only after the handshake.
- Arithmetic op with arith_flag forced 0 at capture → rsp_err = 1; logic op → rsp_carry = 0 even with carry_out = 1.
- RST_TOP pulsed during EXEC → all outputs zero immediately; no stale response after release; the next request completes normally.
- Build without ALU_ARB_RR_EN, both valid for 3 ops → requester 0 granted all 3.
